// File: rtl/instruction_encode.sv
// RV32I instruction encoder and instruction-memory loader.
// Packs field sets into 32-bit words, buffers them, and writes them sequentially with an ack handshake.
module instruction_encode #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  input  logic                  load_addr,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  input  logic                  imem_ack,
  output logic                  err_illegal,
  output logic                  busy,
  output logic [15:0]           words_written
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW_W  = 16;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [DATA_WIDTH-1:0] enc_word;
  logic [DATA_WIDTH-1:0] head_now;
  logic [DATA_WIDTH-1:0] head_after_pop;
  logic                  fmt_legal;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Field packing per instruction format; illegal formats produce no word.
  always_comb begin
    enc_word  = '0;
    fmt_legal = 1'b1;
    case (fmt)
      FMT_R:   enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   enc_word = {imm[31:12], rd, opcode};
      FMT_J:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: fmt_legal = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign push   = accept && fmt_legal;
  assign pop    = (state == S_WRITE) && imem_ack;

  // Head candidates; a word pushed into an empty FIFO is forwarded so it appears one cycle after the handshake.
  always_comb begin
    count_next     = count + CNT_W'(push) - CNT_W'(pop);
    head_now       = (count != '0) ? mem[rd_ptr] : enc_word;
    head_after_pop = (count > CNT_W'(1)) ? mem[rd_ptr + PTR_W'(1)] : enc_word;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // FIFO bookkeeping and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count_next;
      in_ready <= (count_next != CNT_W'(FIFO_DEPTH));
      busy     <= (count_next != '0);
      if (accept && !fmt_legal) begin
        err_illegal <= 1'b1;
      end
    end
  end

  // Write pointer and completed-write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr     <= '0;
      words_written <= '0;
    end else begin
      if (load_addr && !busy) begin
        imem_addr <= start_addr;
      end else if (pop) begin
        imem_addr <= imem_addr + ADDR_WIDTH'(1);
      end
      if (pop && (words_written != {WW_W{1'b1}})) begin
        words_written <= words_written + WW_W'(1);
      end
    end
  end

  // Write-side FSM; request and data hold until the memory acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count_next != '0) begin
            state      <= S_WRITE;
            imem_we    <= 1'b1;
            imem_wdata <= head_now;
          end
        end
        S_WRITE: begin
          if (pop) begin
            if (count_next == '0) begin
              state   <= S_IDLE;
              imem_we <= 1'b0;
            end else begin
              imem_wdata <= head_after_pop;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          imem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encode.sv
// Directed bench for instruction_encode: a scoreboard of expected (addr, word) pairs checked as memory writes complete.
module tb_instruction_encode;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        load_addr;
  logic [7:0]  start_addr;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ack;
  logic        err_illegal;
  logic        busy;
  logic [15:0] words_written;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  logic [7:0]  exp_ptr;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic        hold_valid;
  logic [7:0]  hold_addr;
  logic [31:0] hold_data;

  instruction_encode #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fmt          (fmt),
    .opcode       (opcode),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .funct3       (funct3),
    .funct7       (funct7),
    .imm          (imm),
    .load_addr    (load_addr),
    .start_addr   (start_addr),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .imem_ack     (imem_ack),
    .err_illegal  (err_illegal),
    .busy         (busy),
    .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im, input logic [31:0] exp_word);
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    fmt      = f;
    opcode   = op;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    funct3   = f3;
    funct7   = f7;
    imm      = im;
    in_valid = 1'b1;
    if (f <= 3'd5) begin
      sb.push_back(wr_t'{addr: exp_ptr, data: exp_word});
      exp_ptr++;
    end
    step();
    in_valid = 1'b0;
  endtask

  // R-type add with only rd varying: word is 0x33 with rd in bits 11:7.
  task automatic send_r(input logic [4:0] d);
    send(3'd0, 7'h33, d, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h33 | (32'(d) << 7));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  // Completed writes are popped from the scoreboard; stalled requests must hold still.
  always @(negedge clk) begin
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid && imem_we) begin
        chk("hold_addr", 32'(imem_addr), 32'(hold_addr));
        chk("hold_data", imem_wdata, hold_data);
      end
      if (imem_we && imem_ack) begin
        if (sb.size() == 0) begin
          chk("write_expected", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
          chk("wr_data", imem_wdata, mon_e.data);
        end
      end
      hold_valid = imem_we && !imem_ack;
      hold_addr  = imem_addr;
      hold_data  = imem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    fmt        = 3'd0;
    opcode     = 7'd0;
    rd         = 5'd0;
    rs1        = 5'd0;
    rs2        = 5'd0;
    funct3     = 3'd0;
    funct7     = 7'd0;
    imm        = 32'd0;
    load_addr  = 1'b0;
    start_addr = 8'd0;
    imem_ack   = 1'b0;
    exp_ptr    = 8'd0;
    hold_valid = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    rst = 1'b0;
    step();

    // R/I/S with ack tied high; first word checks one-cycle latency
    imem_ack = 1'b1;
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3);
    chk("lat_we", 32'(imem_we), 32'd1);
    chk("lat_data", imem_wdata, 32'h002081B3);
    chk("lat_addr", 32'(imem_addr), 32'd0);
    send(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00293);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423);
    wait_drain();
    chk("ris_words", 32'(words_written), 32'd3);
    chk("ris_ptr", 32'(imem_addr), 32'd3);

    // B/U/J back to back
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF);
    wait_drain();
    chk("buj_words", 32'(words_written), 32'd6);

    // Backpressure: four accepts fill the buffer
    imem_ack = 1'b0;
    send_r(5'd1);
    send_r(5'd2);
    send_r(5'd3);
    send_r(5'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_we", 32'(imem_we), 32'd1);
    chk("full_addr", 32'(imem_addr), 32'd6);
    step();
    step();
    step();
    chk("stall_words", 32'(words_written), 32'd6);
    imem_ack = 1'b1;
    send_r(5'd5);
    wait_drain();
    chk("bp_words", 32'(words_written), 32'd11);
    chk("bp_ptr", 32'(imem_addr), 32'd11);

    // Pointer load and wrap; a load while busy is ignored
    load_addr  = 1'b1;
    start_addr = 8'hFE;
    step();
    load_addr  = 1'b0;
    chk("load_ptr", 32'(imem_addr), 32'hFE);
    exp_ptr  = 8'hFE;
    imem_ack = 1'b0;
    send_r(5'd7);
    send_r(5'd8);
    send_r(5'd9);
    chk("busy_before_load", 32'(busy), 32'd1);
    load_addr  = 1'b1;
    start_addr = 8'h10;
    step();
    load_addr  = 1'b0;
    chk("load_busy_ignored", 32'(imem_addr), 32'hFE);
    imem_ack = 1'b1;
    wait_drain();
    chk("wrap_ptr", 32'(imem_addr), 32'd1);

    // Illegal format: accepted, flagged, nothing written
    send(3'd6, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'd0);
    chk("illegal_err", 32'(err_illegal), 32'd1);
    chk("illegal_we", 32'(imem_we), 32'd0);
    chk("illegal_busy", 32'(busy), 32'd0);
    step();
    step();
    chk("illegal_err_sticky", 32'(err_illegal), 32'd1);
    chk("illegal_we_later", 32'(imem_we), 32'd0);
    send_r(5'd10);
    wait_drain();
    chk("illegal_words", 32'(words_written), 32'd15);
    chk("illegal_err_final", 32'(err_illegal), 32'd1);

    // Reset in the middle of a stalled write
    imem_ack = 1'b0;
    send_r(5'd11);
    send_r(5'd12);
    send_r(5'd13);
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_words", 32'(words_written), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_err", 32'(err_illegal), 32'd0);
    sb.delete();
    exp_ptr = 8'd0;
    step();
    rst      = 1'b0;
    imem_ack = 1'b1;
    step();
    send_r(5'd14);
    wait_drain();
    chk("post_rst_words", 32'(words_written), 32'd1);
    chk("post_rst_ptr", 32'(imem_addr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_encode.md
# instruction_encode

Instruction encoder and memory loader for the RISC-V core: the inverse of the decode stage. It accepts instruction fields (format, opcode, rd, rs1, rs2, funct3, funct7, immediate) over a valid/ready handshake and packs them into 32-bit RV32I words. The words are buffered in a small FIFO and written sequentially into instruction memory through a write port with an acknowledge. It is used by the test/boot path to fill instruction memory before the core runs.

## Interface
- DATA_WIDTH, 32, instruction word width (fixed at 32; other values unsupported)
- ADDR_WIDTH, 8, instruction memory word-address width
- FIFO_DEPTH, 4, encoded-word buffer depth (power of two, ≥2)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  field set valid
- in_ready  out  1  field set accepted when in_valid && in_ready
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 illegal
- opcode  in  7  instruction[6:0]
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field
- imm  in  32  sign-extended immediate; unused bits ignored
- load_addr  in  1  pulse: load start_addr into the write pointer
- start_addr  in  ADDR_WIDTH  new write address
- imem_we  out  1  write request
- imem_addr  out  ADDR_WIDTH  word address
- imem_wdata  out  DATA_WIDTH  encoded word
- imem_ack  in  1  memory accepts the write this cycle
- err_illegal  out  1  sticky: an illegal fmt was accepted
- busy  out  1  FIFO non-empty or write pending
- words_written  out  16  completed writes, saturates at 0xFFFF

## Operation
- Encoding is combinational on the inputs. The encoded word is registered into the FIFO on handshake:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode (imm[0] ignored)
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode (imm[0] ignored)
- Illegal fmt: the handshake completes but nothing is pushed. err_illegal sets and clears only on rst.
- in_ready = !full. A push while full is impossible; there is no same-cycle push-through when full.
- Write side FSM:
  - IDLE: imem_we=0. Go to WRITE when the FIFO is non-empty.
  - WRITE: imem_we=1, imem_wdata=FIFO head, imem_addr=write pointer. Outputs stay stable until imem_ack.
  - On imem_ack: pop the FIFO, increment the pointer (wrapping 2^ADDR_WIDTH−1 → 0), and increment words_written (saturating). Stay in WRITE if more words remain, else return to IDLE.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- load_addr is honoured only when busy=0. Otherwise it is ignored and there is no error.
- busy = FIFO non-empty || state==WRITE.

## Timing
- Reset values: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, err_illegal=0, busy=0, words_written=0. The FIFO is empty and the FSM is in IDLE.
- Latency: a handshake in cycle N gives imem_we=1 with that word in cycle N+1 (FIFO empty, FSM IDLE).
- Throughput: one word per cycle when imem_ack is held high.
- load_addr in cycle N (busy=0): the write pointer equals start_addr from N+1.
- err_illegal is visible the cycle after the illegal handshake.
- rst asserted mid-write: imem_we drops immediately (async), the FIFO is flushed, and the pointer returns to 0. Words not yet acked are lost.

## Test plan
- R/I/S encodes, imem_ack tied 1:
  - add x3,x1,x2 (opcode 0x33) → 0x002081B3 at addr 0
  - addi x5,x0,-1 (0x13, imm 0xFFFFFFFF) → 0xFFF00293 at addr 1
  - sw x2,8(x1) (0x23, f3=2) → 0x0020A423 at addr 2
  - words_written=3
- B/U/J encodes:
  - beq x0,x0,-4 (0x63, imm 0xFFFFFFFC) → 0xFE000EE3
  - lui x5,0x12345 (0x37, imm 0x12345000) → 0x123452B7
  - jal x1,8 (0x6F) → 0x008000EF
- Backpressure: imem_ack=0 while pushing 5 words.
  - in_ready drops after the 4th accept.
  - imem_addr/imem_wdata stay stable.
  - Releasing ack drains all 5 words in order at consecutive addresses.
- Wrap and load: load_addr with start_addr=0xFE, then write 3 words → addresses 0xFE, 0xFF, 0x00. A load_addr pulse while busy=1 leaves the pointer unchanged.
- Illegal fmt=6 handshake:
  - no imem_we
  - err_illegal=1 next cycle and stays set
  - a following legal word is still written at the expected address
- Reset mid-operation: assert rst with 3 words queued and ack low → imem_we=0 in the same cycle, busy=0, words_written=0. The first write after reset goes to addr 0.
